// File: rtl/timer_pkg.sv
// Shared FSM state and mode encodings for the programmable interval timer.
package timer_pkg;
  localparam logic [0:0] S_IDLE        = 1'b0;
  localparam logic [0:0] S_RUN         = 1'b1;
  localparam logic       MODE_ONESHOT  = 1'b0;
  localparam logic       MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into one-cycle base ticks every TICK_DIV enabled cycles.
// Tick is combinational on the wrap cycle; clear restarts the phase at 0.
module tick_prescaler #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  import timer_pkg::*;

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
    end
  end
endmodule

// File: rtl/prog_interval_timer.sv
// Programmable interval timer: one-shot or periodic, with pause, abort and restart.
// First timeout is high the cycle after edge E0 + period*TICK_DIV; no backpressure.
module prog_interval_timer #(
  parameter int TICK_DIV = 5_000_000,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] period,
  output logic             timeout,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);
  import timer_pkg::*;

  logic [0:0]       state;
  logic [CNT_W-1:0] period_q;
  logic             mode_q;
  logic             start_ok;
  logic             stop_ok;
  logic             tick;
  logic             running;

  assign running  = (state == S_RUN);
  assign start_ok = start && (period != '0);
  assign stop_ok  = stop && running;
  assign busy     = running;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok || stop_ok),
    .enable(enable && running),
    .tick  (tick)
  );

  // Stop outranks start, and both outrank a terminal tick, so a
  // coinciding start/stop silently swallows that interval's pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      period_q  <= '0;
      mode_q    <= MODE_ONESHOT;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (stop_ok) begin
        state     <= S_IDLE;
        remaining <= '0;
      end else if (start_ok) begin
        state     <= S_RUN;
        remaining <= period;
        period_q  <= period;
        mode_q    <= mode;
      end else if (running && tick) begin
        if (remaining <= CNT_W'(1)) begin
          timeout <= 1'b1;
          if (mode_q == MODE_PERIODIC) begin
            remaining <= period_q;
          end else begin
            state     <= S_IDLE;
            remaining <= '0;
          end
        end else begin
          remaining <= remaining - CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: doc/prog_interval_timer.md
# prog_interval_timer

Parametrised, programmable interval timer: the next generation of the fixed one-second timeout path. A prescaler divides `clk` into base ticks. A loadable down-counter counts a run-time period of N ticks and emits a one-cycle `timeout` pulse. It supports one-shot and periodic (auto-reload) modes, plus pause, abort and restart. Game/sequence FSMs instantiate it wherever a delay or repeating heartbeat is needed.

## Interface
- `TICK_DIV`, default 5_000_000, clock cycles per base tick (100 ms at 50 MHz); legal range ≥ 2.
- `CNT_W`, default 8, width of the period and remaining-count fields.
- `clk` input 1: single system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: count-enable; low freezes the prescaler and counter.
- `start` input 1: one-cycle request to load `period` and begin or restart a run.
- `stop` input 1: abort the current run; return to IDLE with no pulse.
- `mode` input 1: 0 = one-shot, 1 = periodic; sampled together with `period` on `start`.
- `period` input CNT_W: number of base ticks per interval.
- `timeout` output 1: registered one-cycle pulse at the end of each interval.
- `busy` output 1: high while in RUN.
- `remaining` output CNT_W: ticks left in the current interval; 0 in IDLE.

## Operation
- The FSM has two states.
  - IDLE: no counting.
  - RUN: the prescaler and counter are active.
- `start` with `period` ≠ 0 is accepted in either state.
  - On acceptance the block latches `period` and `mode`.
  - It sets `remaining` = `period`, clears the prescaler to 0 and enters RUN.
- `start` with `period` = 0 is ignored; state and counters are unchanged.
- In RUN, with `enable` high:
  - The prescaler increments each cycle.
  - At `TICK_DIV`-1 the prescaler wraps to 0 and a base tick occurs; `remaining` decrements.
- Terminal tick (base tick while `remaining` = 1):
  - `timeout` is high in the next cycle.
  - One-shot: go to IDLE; `remaining` = 0.
  - Periodic: stay in RUN; reload `remaining` from the latched period; the prescaler continues from 0.
- With `enable` low, the prescaler, `remaining` and state hold. `start` and `stop` still act.
- `stop` in RUN: go to IDLE, clear the prescaler and `remaining`, no pulse. `stop` in IDLE has no effect.
- Priority, highest first: `rst` > `stop` > `start` > terminal tick. A start or stop coinciding with a terminal tick suppresses that `timeout`.
- Changes to `period` or `mode` while in RUN have no effect until the next `start`.

## Timing
- Reset values: state IDLE, prescaler 0, `remaining` 0, `timeout` 0, `busy` 0, latched period 0, latched mode 0.
- Latency: `start` sampled at edge E0 with `enable` held high. The first `timeout` is high in the cycle following edge E0 + N·`TICK_DIV`.
- Periodic mode: each subsequent pulse follows exactly N·`TICK_DIV` enabled cycles later.
- Each cycle with `enable` low delays the pulse by exactly one cycle.
- `busy` rises the cycle after an accepted `start`.
  - One-shot: `busy` falls in the same cycle `timeout` rises.
  - Periodic: `busy` stays high.
- `timeout` is never wider than one cycle. `remaining` never underflows below 0.
- Prescaler width is clog2(`TICK_DIV`). All arithmetic is unsigned with no carry-out.

## Structure
- Shared package `timer_pkg`:
  - FSM state encodings (S_IDLE, S_RUN).
  - Mode constants (MODE_ONESHOT = 0, MODE_PERIODIC = 1).
- One sub-module, `tick_prescaler` (parameter `TICK_DIV`):
  - Inputs: `clk`, `rst`, `clear`, `enable`.
  - Output: single-cycle `tick`.
- The top level holds the FSM, period/mode latches, down-counter and output register.

## Test plan
All scenarios use `TICK_DIV` = 4 and `CNT_W` = 8.
- One-shot: `start`, `period` = 3, `mode` = 0, `enable` = 1 → single `timeout` 12 cycles after `start`; `busy` falls with it; `remaining` steps 3,2,1,0.
- Periodic: `period` = 2, `mode` = 1 → pulses every 8 cycles for ≥ 4 intervals; `busy` stays 1; `remaining` reloads to 2.
- Pause: one-shot `period` = 3, `enable` low for 5 cycles mid-run → `timeout` at 17 cycles; `remaining` frozen during the gap.
- Abort and zero period:
  - `stop` at cycle 6 → no `timeout`; IDLE, `remaining` 0.
  - `start` with `period` = 0 → stays IDLE.
- Restart collision: periodic `period` = 1; `start` with `period` = 5 on a terminal-tick edge → that pulse suppressed; next pulse 20 cycles later.
- Reset mid-run: `rst` asserted in RUN with `remaining` = 2 → all outputs 0 the next cycle; no pulse after release until a new `start`.
